// File: rtl/dmem_port_arbiter.sv
// Single-port D-MEM arbiter: the pipeline MEM stage has priority, a secondary (debug/DMA)
// requester shares the port and is force-granted after STARVE_LIMIT consecutive denied cycles.
module dmem_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int MEM_AW       = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pipe_req_valid,
    input  logic              i_pipe_req_we,
    input  logic [DBITS-1:0]  i_pipe_req_addr,
    input  logic [DBITS-1:0]  i_pipe_req_wdata,
    output logic              o_pipe_stall,
    output logic              o_pipe_rvalid,
    output logic [DBITS-1:0]  o_pipe_rdata,
    input  logic              i_dma_req_valid,
    input  logic              i_dma_req_we,
    input  logic [DBITS-1:0]  i_dma_req_addr,
    input  logic [DBITS-1:0]  i_dma_req_wdata,
    output logic              o_dma_req_ready,
    output logic              o_dma_rvalid,
    output logic [DBITS-1:0]  o_dma_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [DBITS-1:0]  o_mem_wdata,
    input  logic [DBITS-1:0]  i_mem_rdata,
    output logic              o_dbg_state,
    output logic [1:0]        o_dbg_owner,
    output logic [3:0]        o_dbg_starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {ST_IDLE = 1'b0, ST_LDWAIT = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_PIPE = 2'd1, OWN_DMA = 2'd2} owner_t;

    // Handshake: a DMA request is transferred in a cycle where i_dma_req_valid and
    // o_dma_req_ready are both 1; the requester holds its request stable until then.
    state_t     r_state;
    owner_t     r_owner;
    logic [3:0] r_starve_cnt;

    logic w_pipe_gnt;
    logic w_dma_gnt;
    logic w_pipe_load_gnt;
    logic w_unused_addr_bits;

    always_comb begin
        w_pipe_gnt = 1'b0;
        w_dma_gnt  = 1'b0;
        // Grants are suppressed while reset is held so nothing reaches memory.
        if (!reset) begin
            if (r_state == ST_LDWAIT) begin
                w_dma_gnt = i_dma_req_valid;
            end else if (i_dma_req_valid && (r_starve_cnt == LIMIT)) begin
                w_dma_gnt = 1'b1;
            end else if (i_pipe_req_valid) begin
                w_pipe_gnt = 1'b1;
            end else begin
                w_dma_gnt = i_dma_req_valid;
            end
        end
    end

    assign w_pipe_load_gnt = w_pipe_gnt && !i_pipe_req_we;

    assign o_mem_en    = w_pipe_gnt || w_dma_gnt;
    assign o_mem_we    = (w_pipe_gnt && i_pipe_req_we) || (w_dma_gnt && i_dma_req_we);
    assign o_mem_addr  = w_dma_gnt ? i_dma_req_addr[MEM_AW+1:2] : i_pipe_req_addr[MEM_AW+1:2];
    assign o_mem_wdata = w_dma_gnt ? i_dma_req_wdata : i_pipe_req_wdata;

    // In LDWAIT the pipe request is the load completing this cycle, so it never stalls.
    assign o_pipe_stall    = !reset && (r_state == ST_IDLE) && i_pipe_req_valid &&
                             (w_pipe_load_gnt || w_dma_gnt);
    assign o_dma_req_ready = w_dma_gnt;

    assign o_pipe_rvalid = !reset && (r_state == ST_LDWAIT);
    assign o_pipe_rdata  = i_mem_rdata;
    assign o_dma_rvalid  = !reset && (r_owner == OWN_DMA);
    assign o_dma_rdata   = i_mem_rdata;

    assign o_dbg_state      = r_state;
    assign o_dbg_owner      = r_owner;
    assign o_dbg_starve_cnt = r_starve_cnt;

    assign w_unused_addr_bits = ^{i_pipe_req_addr[1:0], i_pipe_req_addr[DBITS-1:MEM_AW+2],
                                  i_dma_req_addr[1:0], i_dma_req_addr[DBITS-1:MEM_AW+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state <= w_pipe_load_gnt ? ST_LDWAIT : ST_IDLE;

            if (w_pipe_load_gnt) begin
                r_owner <= OWN_PIPE;
            end else if (w_dma_gnt && !i_dma_req_we) begin
                r_owner <= OWN_DMA;
            end else begin
                r_owner <= OWN_NONE;
            end

            if (!i_dma_req_valid || w_dma_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Owns the single port of the data memory (D-MEM) and shares it between two requesters:
  - the pipeline MEM stage, which has priority;
  - a secondary requester (debug/DMA loader) that reads or writes D-MEM while the core runs.
- Sequences pipeline loads as two-cycle operations and stalls the pipeline while a load is outstanding or the port is stolen.
- Guarantees forward progress for the secondary requester with a starvation counter.

Parameters:
- DBITS, 32, data width of both requesters and of the memory word.
- MEM_AW, 14, memory word-address width; byte address bits [MEM_AW+1:2] select the word.
- STARVE_LIMIT, 4, consecutive denied DMA cycles after which DMA is force-granted. Legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pipe_req_valid  in  1  MEM stage has a load or store.
- pipe_req_we  in  1  1 = store, 0 = load.
- pipe_req_addr  in  DBITS  byte address.
- pipe_req_wdata  in  DBITS  store data.
- pipe_stall  out  1  hold the MEM stage and all upstream latches.
- pipe_rvalid  out  1  pipe_rdata valid this cycle.
- pipe_rdata  out  DBITS  load data.
- dma_req_valid  in  1  DMA request, held until accepted.
- dma_req_we  in  1  1 = write.
- dma_req_addr  in  DBITS  byte address.
- dma_req_wdata  in  DBITS  write data.
- dma_req_ready  out  1  request accepted this cycle (valid and ready together).
- dma_rvalid  out  1  dma_rdata valid.
- dma_rdata  out  DBITS  read data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  DBITS  memory write data.
- mem_rdata  in  DBITS  memory read data; registered, valid the cycle after a read with mem_en=1.

Behaviour:
- FSM states:
  - IDLE: default state.
  - LDWAIT: entered the cycle after a pipeline load is issued; lasts exactly 1 cycle, then returns to IDLE.
- Owner tag: a 2-bit register records which requester issued the read now returning (NONE, PIPE, DMA).
- Grant rules in IDLE, evaluated each cycle:
  - DMA is force-granted if dma_req_valid and starve_cnt == STARVE_LIMIT.
  - Otherwise PIPE is granted if pipe_req_valid.
  - Otherwise DMA is granted if dma_req_valid.
  - Otherwise nothing is granted.
- Grant rules in LDWAIT:
  - The pipe request is ignored; it is the load being completed.
  - DMA is granted if dma_req_valid.
- pipe_stall, combinational:
  - 1 in IDLE when PIPE is granted a load.
  - 1 in IDLE when pipe_req_valid but DMA is granted.
  - 0 otherwise, including in LDWAIT.
  - A pipeline store completes in its grant cycle with no stall.
- Memory port:
  - mem_en = any grant.
  - mem_we, mem_addr and mem_wdata come from the granted requester.
  - mem_addr = addr[MEM_AW+1:2]; low two bits and bits above MEM_AW+1 are ignored.
- dma_req_ready = DMA granted.
- Read return: exactly 1-cycle latency after a read grant.
  - pipe_rvalid = 1 in LDWAIT, with pipe_rdata = mem_rdata.
  - dma_rvalid = 1 the cycle after a DMA read grant, with dma_rdata = mem_rdata.
  - Writes produce no rvalid.
  - rdata outputs are don't-care when their rvalid is 0; the bench checks them only with rvalid.
- starve_cnt: 4-bit register.
  - Increments when dma_req_valid and DMA is not granted, saturating at STARVE_LIMIT.
  - Clears to 0 on a DMA grant or when dma_req_valid = 0.
- Simultaneous pipe load and DMA request in IDLE with count below limit:
  - PIPE is granted in cycle N.
  - DMA is granted in cycle N+1 (LDWAIT).
  - DMA read data returns in N+2.
- Reset:
  - State IDLE, starve_cnt 0, owner NONE.
  - pipe_rvalid, dma_rvalid, pipe_stall, dma_req_ready, mem_en and mem_we are all 0 during the reset cycle; no write may reach memory.
  - Reset during LDWAIT aborts the load: no rvalid afterwards, and the pipeline re-issues it.
- The DMA requester must hold its request stable until ready; behaviour on a withdrawn request is undefined.

Test Plan:
- Pipe store to 0x10 with data 0xDEADBEEF and no DMA -> same cycle mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, pipe_stall=0.
- Pipe load from 0x10 after the store -> cycle N: pipe_stall=1, mem_en=1, mem_we=0. Cycle N+1: pipe_rvalid=1, pipe_rdata=0xDEADBEEF, pipe_stall=0. Next cycle back to IDLE.
- STARVE_LIMIT=4, continuous pipe stores and DMA read of 0x20 held from cycle 0 -> dma_req_ready=0 in cycles 0–3. Cycle 4: dma_req_ready=1, pipe_stall=1, mem_addr=8. Cycle 5: dma_rvalid=1, pipe_stall=0, starve_cnt=0.
- Pipe load 0x10 and DMA write 0x40 with data 0x12345678 in the same cycle -> cycle N: PIPE granted. Cycle N+1: DMA granted with mem_we=1, mem_addr=16, while pipe_rvalid=1.
- Reset asserted in LDWAIT -> following cycle pipe_rvalid=0, state IDLE, starve_cnt=0, mem_en=0.
- Pipe store to misaligned address 0x13, and to 0x10013 with MEM_AW=14 -> mem_addr=4 in both cases.
